// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road traffic light phase sequencer with latched side-road request
module traffic_phase_scheduler #(
    parameter int MIN_GREEN    = 8,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int SIDE_GREEN   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       button,
    input  logic       hold,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic [2:0] state,
    output logic       req_pending
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } phase_t;

    localparam logic [7:0] MG_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0] Y_LAST  = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] AR_LAST = 8'(ALL_RED_TIME - 1);
    localparam logic [7:0] SG_LAST = 8'(SIDE_GREEN - 1);

    phase_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       req_q, req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MG;
            timer_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        // Illegal codes recover immediately, even under hold
        if (state_q > AR2) begin
            state_d = MG;
        end else if (!hold && tick) begin
            case (state_q)
                MG: begin
                    if (timer_q >= MG_LAST) begin
                        if (req_q) state_d = MY;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                MY:  if (timer_q == Y_LAST)  state_d = AR1; else timer_d = timer_q + 8'd1;
                AR1: if (timer_q == AR_LAST) state_d = SG;  else timer_d = timer_q + 8'd1;
                SG:  if (timer_q == SG_LAST) state_d = SY;  else timer_d = timer_q + 8'd1;
                SY:  if (timer_q == Y_LAST)  state_d = AR2; else timer_d = timer_q + 8'd1;
                AR2: if (timer_q == AR_LAST) state_d = MG;  else timer_d = timer_q + 8'd1;
                default: state_d = MG;
            endcase
        end
        if (state_d != state_q) timer_d = '0;
        // Entering side green serves the request; a same-cycle press is dropped
        if (state_d == SG && state_q != SG) req_d = 1'b0;
        else                                req_d = req_q | button;
    end

    always_comb begin
        main_red    = 1'b0;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b0;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        case (state_q)
            MG: begin main_green  = 1'b1; side_red    = 1'b1; end
            MY: begin main_yellow = 1'b1; side_red    = 1'b1; end
            SG: begin main_red    = 1'b1; side_green  = 1'b1; end
            SY: begin main_red    = 1'b1; side_yellow = 1'b1; end
            default: begin main_red = 1'b1; side_red = 1'b1; end
        endcase
    end

    assign state       = state_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed vector bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, tick, button, hold;
    logic       main_red, main_yellow, main_green, side_red, side_yellow, side_green;
    logic [2:0] state;
    logic       req_pending;
    logic [5:0] lamps;

    int checks = 0;
    int failures = 0;

    traffic_phase_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .button(button), .hold(hold),
        .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
        .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
        .state(state), .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green};

    typedef struct {
        int         n;
        logic       tick;
        logic       button;
        logic       hold;
        logic [2:0] st;
        logic       req;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] lamp_of(input logic [2:0] s);
        case (s)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] es, input logic er);
        chk({nm, "_state"}, 32'(state), 32'(es));
        chk({nm, "_lamps"}, 32'(lamps), 32'(lamp_of(es)));
        chk({nm, "_req"}, 32'(req_pending), 32'(er));
    endtask

    task automatic step(input logic t, input logic b, input logic h);
        tick = t; button = b; hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; button = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("in_reset", 3'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] hold_exp(input int e);
        if (e < 32) return 3'd0;
        if (e < 44) return 3'd1;
        if (e < 48) return 3'd2;
        if (e < 68) return 3'd3;
        if (e < 88) return 3'd4;
        if (e < 92) return 3'd5;
        return 3'd0;
    endfunction

    initial begin
        // Early request at defaults: n cycles applied, then compared
        vecs[0]  = '{2,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1,  1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[2]  = '{4,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[3]  = '{1,  1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[4]  = '{2,  1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[5]  = '{1,  1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
        vecs[6]  = '{1,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        vecs[7]  = '{4,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0};
        vecs[8]  = '{1,  1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        vecs[9]  = '{3,  1'b1, 1'b0, 1'b0, 3'd5, 1'b0};
        vecs[10] = '{1,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[11] = '{20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].tick, vecs[i].button, vecs[i].hold);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].req);
        end

        // Idle for 100 cycles, then a late request leaves on the following clk
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_all("idle", 3'd0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk_all("late_latch", 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("late_my", 3'd1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_all("late_ar1", 3'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("late_sg", 3'd3, 1'b0);

        // Press during SG is held over and served after a full minimum green
        step(1'b1, 1'b1, 1'b0);
        chk_all("sg_press", 3'd3, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_all("sg_last", 3'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("sg_sy", 3'd4, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        chk_all("sg_ar2", 3'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("sg_mg", 3'd0, 1'b1);
        repeat (7) step(1'b1, 1'b0, 1'b0);
        chk_all("sg_mg_hold7", 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_all("sg_mg_exit8", 3'd1, 1'b1);

        // Tick every 4th cycle, hold for 10 cycles inside SY
        do_reset();
        for (int i = 0; i < 96; i++) begin
            step((i % 4) == 3, i == 0, (i + 1 >= 73) && (i + 1 <= 82));
            chk_all($sformatf("slow_e%0d", i + 1), hold_exp(i + 1), (i + 1) < 48);
        end

        // Reset asserted mid-SG returns to MG in the same cycle
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        repeat (11) step(1'b1, 1'b0, 1'b0);
        chk_all("pre_rst_sg", 3'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("pre_rst_req", 3'd3, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk_all("rst_async", 3'd0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 3'd0, 1'b0);
        rst_n = 1'b1;
        repeat (7) step(1'b1, 1'b1, 1'b0);
        chk_all("post_rst_7", 3'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_all("post_rst_8", 3'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
